// File: rtl/toothless_ctrl_if.sv
// Instruction-fetch and data-access handshake bundle between the control FSM
// and the memory side. master = controller, slave = memory/bus responder.
interface toothless_ctrl_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;

    logic        data_req_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;

    modport master (
        output instr_req_o, instr_addr_o, data_req_o, data_we_o, data_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, data_gnt_i, data_rvalid_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o, data_req_o, data_we_o, data_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, data_gnt_i, data_rvalid_i
    );
endinterface

// File: rtl/toothless_ctrl.sv
// Multi-cycle control FSM for a non-pipelined RISC-V style core: fetch,
// execute, optional memory access, write-back/retire, and a sticky trap state.
module toothless_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    toothless_ctrl_if.master      bus,
    input  logic                  instr_invalid_i,
    input  logic                  rd_used_i,
    input  logic                  is_load_i,
    input  logic                  is_store_i,
    input  logic                  is_branch_i,
    input  logic                  is_jump_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic [31:0]           instr_o,
    output logic                  rf_we_o,
    output logic [1:0]            wb_sel_o,
    output logic [31:0]           pc_o,
    output logic [31:0]           instret_o,
    output logic                  trap_o,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MREQ  = 3'd3,
        S_MWAIT = 3'd4,
        S_WB    = 3'd5,
        S_TRAP  = 3'd6
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instret_q;
    logic [31:0] alu_addr;
    logic        redirect;
    logic        misaligned;

    assign alu_addr   = alu_result_i[31:0];
    assign redirect   = is_jump_i | (is_branch_i & branch_taken_i);
    // A redirect to a non-word-aligned target traps instead of retiring.
    assign misaligned = redirect & (alu_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= BOOT_ADDR;
            instr_q   <= NOP_INSTR;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IWAIT && bus.instr_rvalid_i) begin
                instr_q <= bus.instr_rdata_i;
            end
            if (state_q == S_WB && !misaligned) begin
                pc_q      <= redirect ? alu_addr : pc_q + 32'd4;
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.instr_req_o  = 1'b0;
        bus.instr_addr_o = pc_q;
        bus.data_req_o   = 1'b0;
        bus.data_we_o    = 1'b0;
        bus.data_addr_o  = 32'd0;
        rf_we_o          = 1'b0;
        wb_sel_o         = 2'd0;

        case (state_q)
            S_FETCH: begin
                bus.instr_req_o = 1'b1;
                if (bus.instr_gnt_i) state_d = S_IWAIT;
            end
            S_IWAIT: begin
                if (bus.instr_rvalid_i) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (instr_invalid_i)              state_d = S_TRAP;
                else if (is_load_i || is_store_i) state_d = S_MREQ;
                else                              state_d = S_WB;
            end
            S_MREQ: begin
                bus.data_req_o  = 1'b1;
                bus.data_we_o   = is_store_i;
                bus.data_addr_o = alu_addr;
                if (bus.data_gnt_i) state_d = S_MWAIT;
            end
            S_MWAIT: begin
                if (bus.data_rvalid_i) state_d = S_WB;
            end
            S_WB: begin
                if (is_load_i)      wb_sel_o = 2'd1;
                else if (is_jump_i) wb_sel_o = 2'd2;
                if (misaligned) begin
                    state_d = S_TRAP;
                end else begin
                    rf_we_o = rd_used_i & ~is_store_i & ~is_branch_i & (instr_q[11:7] != 5'd0);
                    state_d = S_FETCH;
                end
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // Reset silences every request and strobe in the same cycle it is seen.
        if (rst_n) begin
            state_d         = S_FETCH;
            bus.instr_req_o = 1'b0;
            bus.data_req_o  = 1'b0;
            bus.data_we_o   = 1'b0;
            rf_we_o         = 1'b0;
            wb_sel_o        = 2'd0;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign instret_o = instret_q;
    assign trap_o    = (state_q == S_TRAP) & ~rst_n;
    assign state_o   = state_q;

endmodule

// File: doc/toothless_ctrl.md
TOOTHLESS_CTRL -- requirements
Module: toothless_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, datapath width; BOOT_ADDR, default 32'h0000_0000, first fetch address.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-high (1 = reset), sampled on clk.
REQ-005 instr_req_o/instr_addr_o  output  1/32  fetch request and address (= pc_o).
REQ-006 instr_gnt_i/instr_rvalid_i/instr_rdata_i  input  1/1/32  fetch grant, response valid, fetched word.
REQ-007 instr_o  output  32  latched instruction register, fed to decoder.
REQ-008 instr_invalid_i, rd_used_i, is_load_i, is_store_i, is_branch_i, is_jump_i  input  1 each  decoder class flags for instr_o.
REQ-009 branch_taken_i  input  1  comparator result; alu_result_i  input  DATA_WIDTH  target or memory address.
REQ-010 data_req_o/data_we_o/data_addr_o  output  1/1/32  data access request, write enable, address.
REQ-011 data_gnt_i/data_rvalid_i  input  1/1  data grant, load/store completion.
REQ-012 rf_we_o  output  1  register-file write strobe; wb_sel_o  output  2  0=ALU, 1=MEM, 2=PC+4.
REQ-013 pc_o  output  32  current PC; instret_o  output  32  retired-instruction count; trap_o  output  1  sticky illegal-instruction flag; state_o  output  3  FSM state.

Function
REQ-014 SHALL implement FSM states FETCH(0), IWAIT(1), EXEC(2), MREQ(3), MWAIT(4), WB(5), TRAP(6).
REQ-015 FETCH: instr_req_o=1, held with stable address until instr_gnt_i=1; on grant -> IWAIT.
REQ-016 IWAIT: instr_req_o=0; on instr_rvalid_i=1 latch instr_rdata_i into instr_o -> EXEC; gnt and rvalid in same cycle not allowed (rvalid only after gnt cycle).
REQ-017 EXEC (exactly one cycle): instr_invalid_i=1 -> TRAP; else is_load_i|is_store_i -> MREQ; else -> WB.
REQ-018 MREQ: data_req_o=1, data_we_o=is_store_i, data_addr_o=alu_result_i, held until data_gnt_i=1 -> MWAIT.
REQ-019 MWAIT: data_req_o=0; on data_rvalid_i=1 -> WB.
REQ-020 WB (one cycle): rf_we_o = rd_used_i & ~is_store_i & ~is_branch_i & (rd field nonzero); wb_sel_o = 1 for load, 2 for jump, else 0.
REQ-021 WB: pc_o <= alu_result_i if is_jump_i or (is_branch_i & branch_taken_i), else pc_o+4 (mod 2^32, wraps); instret_o +1 (wraps 0xFFFF_FFFF -> 0); -> FETCH.
REQ-022 rf_we_o SHALL be 0 in every state except WB.
REQ-023 Taken target with alu_result_i[1:0] != 0 -> TRAP instead of PC update, no register write, instret_o unchanged.
REQ-024 TRAP: trap_o=1, no requests issued; remains until reset.
REQ-025 Fetch-to-retire latency, zero-wait memory: ALU op 4 cycles (FETCH, IWAIT, EXEC, WB); load/store 6 cycles.
REQ-026 Stray gnt/rvalid outside the waiting state SHALL be ignored.

Reset
REQ-027 While rst_n=1: state FETCH, pc_o=BOOT_ADDR, instr_o=0x0000_0013 (NOP), instret_o=0, trap_o=0, all request/strobe outputs 0.
REQ-028 First cycle after rst_n falls: instr_req_o=1, instr_addr_o=BOOT_ADDR.
REQ-029 Reset mid-transaction (any state, including TRAP or MWAIT) SHALL abandon the access, not retire, and return to reset values next cycle.

Verification
REQ-030 Zero-wait addi x1,x0,5 (0x00500093) at 0x0 -> rf_we_o=1 in cycle 4, wb_sel_o=0, pc_o=0x4, instret_o=1.
REQ-031 Load with instr_gnt_i 3 cycles late, data_rvalid_i 2 cycles late -> request stable while waiting, rf_we_o=1 with wb_sel_o=1, pc_o +4.
REQ-032 Taken branch, alu_result_i=0x100 -> pc_o=0x100, rf_we_o=0; misaligned 0x102 -> TRAP, trap_o=1, no further instr_req_o.
REQ-033 instr_invalid_i=1 in EXEC -> state_o=6, instret_o unchanged; rst_n pulse -> pc_o=BOOT_ADDR, trap_o=0.
REQ-034 pc_o=0xFFFF_FFFC, non-branch retire -> pc_o=0x0; instret_o preloaded 0xFFFF_FFFF via forced retirements -> 0x0.
